// File: rtl/decode_stage_pkg.sv
// Shared decode types: uop layout, opcode/funct7 constants, immediate helpers
// and the skid-buffer state encoding used by decode_stage.
package decode_stage_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef logic [11:0] imm_i_t;
   typedef logic [11:0] imm_s_t;
   typedef logic [12:0] imm_b_t;
   typedef logic [19:0] imm_u_t;
   typedef logic [20:0] imm_j_t;

   typedef enum logic [3:0] {
      OPTYPE_ALU, OPTYPE_LOAD, OPTYPE_STORE, OPTYPE_BRANCH, OPTYPE_JAL,
      OPTYPE_JALR, OPTYPE_LUI, OPTYPE_AUIPC, OPTYPE_SYSTEM, OPTYPE_CSR,
      OPTYPE_EXC
   } optype_e;

   typedef enum logic [3:0] {
      ADDITION, SUBTRACTION, SHIFT_LEFT, SET_LESS, SET_LESS_U,
      BIT_XOR, SHIFT_RIGHT_L, SHIFT_RIGHT_A, BIT_OR, BIT_AND
   } alu_op_e;

   typedef enum logic [1:0] {RES_ADDER, RES_LOGIC, RES_SHIFT, RES_CMP} res_sel_e;
   typedef enum logic {NO, YES} opd_sel_e;

   typedef enum logic [1:0] {DEC_EMPTY, DEC_ONE, DEC_TWO} dec_state_e;

   typedef struct packed {
      optype_e     optype;
      alu_op_e     op;
      res_sel_e    res_sel;
      opd_sel_e    alu_cu_input_opd3_opd4_sel;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic        rs1_valid;
      logic [4:0]  rs2;
      logic        rs2_valid;
      logic [4:0]  rd;
      logic        rd_valid;
      logic [31:0] imm;
      logic        imm_valid;
   } uop_t;

   localparam int unsigned UOP_W = $bits(uop_t);

   function automatic logic [31:0] imm_i(input logic [31:0] instr);
      imm_i_t f = instr[31:20];
      return {{20{f[11]}}, f};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] instr);
      imm_s_t f = {instr[31:25], instr[11:7]};
      return {{20{f[11]}}, f};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      imm_b_t f = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      return {{19{f[12]}}, f};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] instr);
      imm_u_t f = instr[31:12];
      return {f, 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      imm_j_t f = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      return {{11{f[20]}}, f};
   endfunction

   function automatic alu_op_e alu_op_of(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'b000:  return alt ? SUBTRACTION : ADDITION;
         3'b001:  return SHIFT_LEFT;
         3'b010:  return SET_LESS;
         3'b011:  return SET_LESS_U;
         3'b100:  return BIT_XOR;
         3'b101:  return alt ? SHIFT_RIGHT_A : SHIFT_RIGHT_L;
         3'b110:  return BIT_OR;
         default: return BIT_AND;
      endcase
   endfunction

   function automatic res_sel_e res_sel_of(input alu_op_e op);
      case (op)
         SHIFT_LEFT, SHIFT_RIGHT_L, SHIFT_RIGHT_A: return RES_SHIFT;
         SET_LESS, SET_LESS_U:                     return RES_CMP;
         BIT_XOR, BIT_OR, BIT_AND:                 return RES_LOGIC;
         default:                                  return RES_ADDER;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and dispatch-side handshake bundle of decode_stage.
// slave = the decode stage's view, master = the surrounding pipeline's view.
interface decode_stage_if
   import decode_stage_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned LANES       = 2,
   parameter int unsigned PC_WIDTH    = 32
);
   logic                         in_valid;
   logic                         in_ready;
   logic [LANES*INSTR_WIDTH-1:0] in_instr;
   logic [LANES-1:0]             in_lane_valid;
   logic [PC_WIDTH-1:0]          in_pc;

   logic                         out_valid;
   logic                         out_ready;
   logic [LANES*UOP_W-1:0]       out_uop;
   logic [LANES-1:0]             out_lane_valid;
   logic [LANES-1:0]             out_lane_nop;
   logic [PC_WIDTH-1:0]          out_pc;
   logic [LANES-1:0]             out_illegal;

   modport master (
      output in_valid, in_instr, in_lane_valid, in_pc, out_ready,
      input  in_ready, out_valid, out_uop, out_lane_valid, out_lane_nop,
             out_pc, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_lane_valid, in_pc, out_ready,
      output in_ready, out_valid, out_uop, out_lane_valid, out_lane_nop,
             out_pc, out_illegal
   );
endinterface

// File: rtl/decode_stage_lane.sv
// Combinational single-instruction decoder (module decode_lane).
// QU_DECODE_ILLEGAL_TRAP_EN: illegal lanes become OPTYPE_EXC uops instead of being squashed.
module decode_lane
   import decode_stage_pkg::*;
(
   input  logic [31:0] instr,
   input  logic        lane_valid,
   output uop_t        uop,
   output logic        uop_valid,
   output logic        nop,
   output logic        illegal
);
   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic       rd_zero;
   logic       alt;
   logic       bad;
   logic       is_nop;
   uop_t       dec;

   assign opcode  = instr[6:0];
   assign rd      = instr[11:7];
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign rd_zero = (rd == 5'd0);
   assign alt     = funct7[5];

   always_comb begin
      dec        = '0;
      bad        = 1'b0;
      is_nop     = 1'b0;
      dec.funct3 = funct3;
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.rd     = rd;
      unique case (opcode)
         OPC_OP: begin
            dec.op        = alu_op_of(funct3, alt);
            dec.rs1_valid = 1'b1;
            dec.rs2_valid = 1'b1;
            dec.rd_valid  = !rd_zero;
            is_nop        = rd_zero;
            if (funct7 == FUNCT7_ALT)
               bad = !(funct3 == 3'b000 || funct3 == 3'b101);
            else if (funct7 != FUNCT7_BASE)
               bad = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.op        = alu_op_of(funct3, (funct3 == 3'b101) && alt);
            dec.rs1_valid = 1'b1;
            dec.rd_valid  = !rd_zero;
            dec.imm       = imm_i(instr);
            dec.imm_valid = 1'b1;
            is_nop        = rd_zero;
            // shift-immediates reuse imm[11:5] as a funct7 field
            if (funct3 == 3'b001)
               bad = (funct7 != FUNCT7_BASE);
            else if (funct3 == 3'b101)
               bad = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
         end
         OPC_LOAD: begin
            dec.optype    = OPTYPE_LOAD;
            dec.rs1_valid = 1'b1;
            dec.rd_valid  = !rd_zero;
            dec.imm       = imm_i(instr);
            dec.imm_valid = 1'b1;
            is_nop        = rd_zero;
            bad           = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            dec.optype    = OPTYPE_STORE;
            dec.rs1_valid = 1'b1;
            dec.rs2_valid = 1'b1;
            dec.imm       = imm_s(instr);
            dec.imm_valid = 1'b1;
            bad           = funct3[2] || (funct3[1:0] == 2'b11);
         end
         OPC_BRANCH: begin
            dec.optype    = OPTYPE_BRANCH;
            dec.op        = funct3[2] ? (funct3[1] ? SET_LESS_U : SET_LESS) : SUBTRACTION;
            dec.rs1_valid = 1'b1;
            dec.rs2_valid = 1'b1;
            dec.imm       = imm_b(instr);
            dec.imm_valid = 1'b1;
            bad           = (funct3[2:1] == 2'b01);
         end
         OPC_JAL: begin
            dec.optype    = OPTYPE_JAL;
            dec.rd_valid  = 1'b1;
            dec.imm       = imm_j(instr);
            dec.imm_valid = 1'b1;
         end
         OPC_JALR: begin
            dec.optype    = OPTYPE_JALR;
            dec.rs1_valid = 1'b1;
            dec.rd_valid  = 1'b1;
            dec.imm       = imm_i(instr);
            dec.imm_valid = 1'b1;
            bad           = (funct3 != 3'b000);
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.optype    = (opcode == OPC_LUI) ? OPTYPE_LUI : OPTYPE_AUIPC;
            dec.rd_valid  = !rd_zero;
            dec.imm       = imm_u(instr);
            dec.imm_valid = 1'b1;
            is_nop        = rd_zero;
         end
         OPC_SYSTEM: begin
            dec.imm       = imm_i(instr);
            dec.imm_valid = 1'b1;
            if (funct3 == 3'b000) begin
               dec.optype = OPTYPE_SYSTEM;
            end else begin
               dec.optype    = OPTYPE_CSR;
               dec.rs1_valid = !funct3[2];
               dec.rd_valid  = !rd_zero;
               bad           = (funct3 == 3'b100);
            end
         end
         default: bad = 1'b1;
      endcase
      dec.res_sel = res_sel_of(dec.op);
      if (dec.op == SET_LESS || dec.op == SET_LESS_U)
         dec.alu_cu_input_opd3_opd4_sel = YES;
   end

   always_comb begin
      uop       = '0;
      uop_valid = 1'b0;
      nop       = 1'b0;
      illegal   = 1'b0;
      if (lane_valid) begin
         illegal = bad;
         if (!bad) begin
            uop       = dec;
            uop_valid = 1'b1;
            nop       = is_nop;
         end
`ifdef QU_DECODE_ILLEGAL_TRAP_EN
         else begin
            uop.optype = OPTYPE_EXC;
            uop.imm    = instr;
            uop_valid  = 1'b1;
         end
`endif
      end
   end
endmodule

// File: rtl/decode_stage.sv
// Registered multi-lane decode stage with a two-entry skid buffer between fetch
// and rename. Honors QU_DECODE_ILLEGAL_TRAP_EN through decode_lane.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned LANES       = 2,
   parameter int unsigned PC_WIDTH    = 32
)(
   input logic            clk,
   input logic            rst_n,
   input logic            flush,
   decode_stage_if.slave  bus
);
   typedef struct packed {
      logic [LANES*UOP_W-1:0] uop;
      logic [LANES-1:0]       lane_valid;
      logic [LANES-1:0]       nop;
      logic [LANES-1:0]       illegal;
      logic [PC_WIDTH-1:0]    pc;
   } bundle_t;

   logic [LANES*UOP_W-1:0] dec_uop;
   logic [LANES-1:0]       dec_valid;
   logic [LANES-1:0]       dec_nop;
   logic [LANES-1:0]       dec_illegal;

   bundle_t    in_b, out_q, out_d, skid_q, skid_d;
   dec_state_e state_q, state_d;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       accept;
   logic       consume;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      uop_t lane_uop;
      decode_lane u_lane (
         .instr      (bus.in_instr[i*INSTR_WIDTH +: 32]),
         .lane_valid (bus.in_lane_valid[i]),
         .uop        (lane_uop),
         .uop_valid  (dec_valid[i]),
         .nop        (dec_nop[i]),
         .illegal    (dec_illegal[i])
      );
      assign dec_uop[i*UOP_W +: UOP_W] = lane_uop;
   end

   always_comb begin
      in_b            = '0;
      in_b.uop        = dec_uop;
      in_b.lane_valid = dec_valid;
      in_b.nop        = dec_nop;
      in_b.illegal    = dec_illegal;
      in_b.pc         = bus.in_pc;
   end

   assign accept  = bus.in_valid && in_ready_q;
   assign consume = out_valid_q && bus.out_ready;

   // Idle registers are cleared so the output bus reads zero whenever out_valid=0.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = DEC_EMPTY;
         out_d   = '0;
         skid_d  = '0;
      end else begin
         unique case (state_q)
            DEC_EMPTY: begin
               if (accept) begin
                  state_d = DEC_ONE;
                  out_d   = in_b;
               end
            end
            DEC_ONE: begin
               if (accept && consume) begin
                  out_d = in_b;
               end else if (accept) begin
                  state_d = DEC_TWO;
                  skid_d  = in_b;
               end else if (consume) begin
                  state_d = DEC_EMPTY;
                  out_d   = '0;
               end
            end
            DEC_TWO: begin
               if (consume) begin
                  state_d = DEC_ONE;
                  out_d   = skid_q;
                  skid_d  = '0;
               end
            end
            default: state_d = DEC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DEC_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != DEC_TWO);
         out_valid_q <= (state_d != DEC_EMPTY);
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_uop        = out_q.uop;
   assign bus.out_lane_valid = out_q.lane_valid;
   assign bus.out_lane_nop   = out_q.nop;
   assign bus.out_illegal    = out_q.illegal;
   assign bus.out_pc         = out_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// handshake run scored against a queue-based reference model.
module tb_decode_stage;
   import decode_stage_pkg::*;

   localparam int unsigned LANES = 2;
   localparam int NUM_BUNDLES = 10000;
   localparam int CYCLE_CAP   = 60000;

   typedef struct {
      logic [31:0]                pc;
      logic [LANES-1:0]           mask;
      logic [LANES-1:0][4:0]      rd;
      logic [LANES-1:0][1:0]      kind;
      logic [LANES-1:0][31:0]     imm;
   } exp_t;

   logic clk;
   logic rst_n;
   logic flush;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   decode_stage_if #(.INSTR_WIDTH(32), .LANES(LANES), .PC_WIDTH(32)) bus ();

   decode_stage #(.INSTR_WIDTH(32), .LANES(LANES), .PC_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic uop_t lane_uop(input int i);
      return uop_t'(bus.out_uop[i*UOP_W +: UOP_W]);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
      checks++; if (bus.out_uop !== '0) begin errors++; $display("FAIL reset_out_uop got %h want 0", bus.out_uop); end
      checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", bus.out_pc); end
      checks++; if ({bus.out_lane_valid, bus.out_lane_nop, bus.out_illegal} !== '0) begin
         errors++; $display("FAIL reset_masks got %b want 0", {bus.out_lane_valid, bus.out_lane_nop, bus.out_illegal});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add_sub();
      uop_t u0, u1;
      @(negedge clk);
      bus.in_instr      = {32'h407302B3, 32'h002081B3};
      bus.in_lane_valid = 2'b11;
      bus.in_pc         = 32'h0000_1000;
      bus.in_valid      = 1'b1;
      bus.out_ready     = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      u0 = lane_uop(0);
      u1 = lane_uop(1);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addsub_out_valid got %0b want 1", bus.out_valid); end
      checks++; if (u0.op !== ADDITION) begin errors++; $display("FAIL addsub_lane0_op got %0d want %0d", u0.op, ADDITION); end
      checks++; if (u0.rd !== 5'd3) begin errors++; $display("FAIL addsub_lane0_rd got %0d want 3", u0.rd); end
      checks++; if (u1.op !== SUBTRACTION) begin errors++; $display("FAIL addsub_lane1_op got %0d want %0d", u1.op, SUBTRACTION); end
      checks++; if (u1.rs1 !== 5'd6 || u1.rs2 !== 5'd7) begin
         errors++; $display("FAIL addsub_lane1_rs got %0d/%0d want 6/7", u1.rs1, u1.rs2);
      end
      checks++; if (bus.out_pc !== 32'h0000_1000) begin errors++; $display("FAIL addsub_pc got %h want 00001000", bus.out_pc); end
      checks++; if (bus.out_lane_valid !== 2'b11) begin errors++; $display("FAIL addsub_lane_valid got %b want 11", bus.out_lane_valid); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addsub_drained got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_nop();
      uop_t u0;
      @(negedge clk);
      bus.in_instr      = {32'hFFFF_FFFF, 32'h0000_0013};
      bus.in_lane_valid = 2'b01;
      bus.in_pc         = 32'h0000_2000;
      bus.in_valid      = 1'b1;
      bus.out_ready     = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      u0 = lane_uop(0);
      checks++; if (bus.out_lane_nop !== 2'b01) begin errors++; $display("FAIL nop_mask got %b want 01", bus.out_lane_nop); end
      checks++; if (u0.imm_valid !== 1'b1) begin errors++; $display("FAIL nop_imm_valid got %0b want 1", u0.imm_valid); end
      checks++; if (u0.rd_valid !== 1'b0) begin errors++; $display("FAIL nop_rd_valid got %0b want 0", u0.rd_valid); end
      checks++; if (bus.out_lane_valid !== 2'b01) begin errors++; $display("FAIL nop_lane_valid got %b want 01", bus.out_lane_valid); end
      checks++; if (lane_uop(1) !== '0) begin errors++; $display("FAIL nop_invalid_lane_uop got %h want 0", lane_uop(1)); end
      checks++; if (bus.out_illegal !== 2'b00) begin errors++; $display("FAIL nop_illegal got %b want 00", bus.out_illegal); end
      @(negedge clk);
   endtask

   task automatic test_illegal();
      uop_t u0;
      @(negedge clk);
      bus.in_instr      = {32'h002081B3, 32'h022081B3};
      bus.in_lane_valid = 2'b11;
      bus.in_pc         = 32'h0000_3000;
      bus.in_valid      = 1'b1;
      bus.out_ready     = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      u0 = lane_uop(0);
      checks++; if (bus.out_illegal !== 2'b01) begin errors++; $display("FAIL illegal_mask got %b want 01", bus.out_illegal); end
`ifdef QU_DECODE_ILLEGAL_TRAP_EN
      checks++; if (bus.out_lane_valid !== 2'b11) begin errors++; $display("FAIL illegal_lane_valid got %b want 11", bus.out_lane_valid); end
      checks++; if (u0.optype !== OPTYPE_EXC) begin errors++; $display("FAIL illegal_optype got %0d want %0d", u0.optype, OPTYPE_EXC); end
      checks++; if (u0.imm !== 32'h022081B3) begin errors++; $display("FAIL illegal_imm got %h want 022081b3", u0.imm); end
      checks++; if ({u0.rs1_valid, u0.rs2_valid, u0.rd_valid} !== 3'b000) begin
         errors++; $display("FAIL illegal_reg_valids got %b want 000", {u0.rs1_valid, u0.rs2_valid, u0.rd_valid});
      end
`else
      checks++; if (bus.out_lane_valid !== 2'b10) begin errors++; $display("FAIL illegal_lane_valid got %b want 10", bus.out_lane_valid); end
`endif
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] want_pc [3];
      logic [LANES*UOP_W-1:0] held_uop;
      int got;
      bit c_sent;
      want_pc[0] = 32'h0000_4000;
      want_pc[1] = 32'h0000_4100;
      want_pc[2] = 32'h0000_4200;
      @(negedge clk);
      bus.out_ready     = 1'b0;
      bus.in_lane_valid = 2'b11;
      bus.in_instr      = {32'h00A00093, 32'h002081B3};
      bus.in_pc         = want_pc[0];
      bus.in_valid      = 1'b1;
      @(negedge clk);
      bus.in_instr = {32'h00B00113, 32'h407302B3};
      bus.in_pc    = want_pc[1];
      @(negedge clk);
      bus.in_pc = want_pc[2];
      held_uop  = bus.out_uop;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %0b want 0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== want_pc[0]) begin
         errors++; $display("FAIL b2b_held_first got valid=%0b pc=%h want 1/%h", bus.out_valid, bus.out_pc, want_pc[0]);
      end
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full got %0b want 0", bus.in_ready); end
      checks++; if (bus.out_pc !== want_pc[0] || bus.out_uop !== held_uop) begin
         errors++; $display("FAIL b2b_stable got pc=%h want %h", bus.out_pc, want_pc[0]);
      end
      bus.out_ready = 1'b1;
      got    = 0;
      c_sent = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (c_sent) bus.in_valid = 1'b0;
         if (bus.out_valid) begin
            checks++;
            if (got >= 3) begin
               errors++; $display("FAIL b2b_extra got pc=%h want none", bus.out_pc);
            end else if (bus.out_pc !== want_pc[got]) begin
               errors++; $display("FAIL b2b_order got pc=%h want %h", bus.out_pc, want_pc[got]);
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) c_sent = 1'b1;
         @(negedge clk);
      end
      checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      bus.out_ready     = 1'b0;
      bus.in_lane_valid = 2'b11;
      bus.in_instr      = {32'h002081B3, 32'h002081B3};
      bus.in_pc         = 32'h0000_5000;
      bus.in_valid      = 1'b1;
      @(negedge clk);
      bus.in_pc = 32'h0000_5100;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_two got %0b want 0", bus.in_ready); end
      flush     = 1'b1;
      bus.in_pc = 32'h0000_5200;
      @(negedge clk);
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_two_out_valid got %0b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_two_in_ready got %0b want 1", bus.in_ready); end
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got pc=%h want none", bus.out_pc); end
      end
      // flush in ONE with a concurrent acceptable bundle
      bus.out_ready = 1'b0;
      bus.in_pc     = 32'h0000_5300;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      flush     = 1'b1;
      bus.in_pc = 32'h0000_5400;
      @(negedge clk);
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_out_valid got %0b want 0", bus.out_valid); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_ghost got pc=%h want none", bus.out_pc); end
   endtask

   task automatic gen_bundle(output exp_t e, output logic [LANES*32-1:0] instrs);
      e.pc   = $urandom() & 32'hFFFF_FFFC;
      instrs = '0;
      for (int i = 0; i < LANES; i++) begin
         logic [4:0]  rd, rs1, rs2;
         logic [11:0] i12;
         logic [19:0] u20;
         logic [31:0] w;
         int          k;
         rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         rs1 = 5'($urandom_range(0, 31));
         rs2 = 5'($urandom_range(0, 31));
         i12 = 12'($urandom());
         u20 = 20'($urandom());
         k   = $urandom_range(0, 2);
         e.mask[i] = ($urandom_range(0, 3) != 0);
         e.rd[i]   = rd;
         e.kind[i] = 2'(k);
         if (k == 0) begin
            w        = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            e.imm[i] = 32'h0;
         end else if (k == 1) begin
            w        = {i12, rs1, 3'b000, rd, 7'h13};
            e.imm[i] = 32'($signed(i12));
         end else begin
            w        = {u20, rd, 7'h37};
            e.imm[i] = 32'(u20) * 32'd4096;
         end
         instrs[i*32 +: 32] = w;
      end
   endtask

   task automatic test_random();
      exp_t cur, e;
      logic [LANES*32-1:0] instrs;
      int  sent = 0;
      int  cyc  = 0;
      bit  did_rst = 1'b0;
      q.delete();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      while ((sent < NUM_BUNDLES || q.size() != 0) && cyc < CYCLE_CAP) begin
         @(negedge clk);
         cyc++;
         if (!did_rst && sent >= NUM_BUNDLES / 2 && q.size() != 0) begin
            did_rst       = 1'b1;
            rst_n         = 1'b0;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            #1;
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
               errors++; $display("FAIL rand_reset_handshake got valid=%0b ready=%0b want 0/1", bus.out_valid, bus.in_ready);
            end
            checks++; if (bus.out_uop !== '0 || bus.out_pc !== 32'h0 || bus.out_lane_valid !== '0 || bus.out_lane_nop !== '0 || bus.out_illegal !== '0) begin
               errors++; $display("FAIL rand_reset_outputs got pc=%h lv=%b want 0", bus.out_pc, bus.out_lane_valid);
            end
            q.delete();
            @(negedge clk);
            rst_n = 1'b1;
         end
         if (sent < NUM_BUNDLES && $urandom_range(0, 3) != 0) begin
            gen_bundle(cur, instrs);
            bus.in_instr      = instrs;
            bus.in_lane_valid = cur.mask;
            bus.in_pc         = cur.pc;
            bus.in_valid      = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         bus.out_ready = (sent >= NUM_BUNDLES) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL rand_unexpected got pc=%h want none", bus.out_pc);
            end else begin
               e = q.pop_front();
               if (bus.out_pc !== e.pc) begin
                  errors++; $display("FAIL rand_pc got %h want %h", bus.out_pc, e.pc);
               end
               checks++; if (bus.out_lane_valid !== e.mask) begin
                  errors++; $display("FAIL rand_lane_valid got %b want %b", bus.out_lane_valid, e.mask);
               end
               for (int i = 0; i < LANES; i++) begin
                  uop_t u;
                  u = lane_uop(i);
                  checks++;
                  if (!e.mask[i]) begin
                     if (u !== '0 || bus.out_lane_nop[i] !== 1'b0) begin
                        errors++; $display("FAIL rand_idle_lane%0d got uop=%h nop=%0b want 0", i, u, bus.out_lane_nop[i]);
                     end
                  end else begin
                     if (u.rd !== e.rd[i] || u.rd_valid !== (e.rd[i] != 5'd0) || bus.out_lane_nop[i] !== (e.rd[i] == 5'd0)) begin
                        errors++; $display("FAIL rand_lane%0d_rd got rd=%0d rdv=%0b nop=%0b want rd=%0d", i, u.rd, u.rd_valid, bus.out_lane_nop[i], e.rd[i]);
                     end
                     checks++;
                     if (u.imm_valid !== (e.kind[i] != 2'd0) || (e.kind[i] != 2'd0 && u.imm !== e.imm[i])) begin
                        errors++; $display("FAIL rand_lane%0d_imm got v=%0b imm=%h want %h", i, u.imm_valid, u.imm, e.imm[i]);
                     end
                  end
               end
               checks++; if (bus.out_illegal !== '0) begin errors++; $display("FAIL rand_illegal got %b want 0", bus.out_illegal); end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(cur);
            sent++;
         end
      end
      bus.in_valid  = 1'b0;
      checks++; if (sent < NUM_BUNDLES || q.size() != 0) begin
         errors++; $display("FAIL rand_timeout got sent=%0d pending=%0d want %0d/0", sent, q.size(), NUM_BUNDLES);
      end
      checks++; if (!did_rst) begin errors++; $display("FAIL rand_reset_skipped got 0 want 1"); end
   endtask

   initial begin
      rst_n             = 1'b0;
      flush             = 1'b0;
      bus.in_valid      = 1'b0;
      bus.in_instr      = '0;
      bus.in_lane_valid = '0;
      bus.in_pc         = '0;
      bus.out_ready     = 1'b0;
      test_reset();
      test_add_sub();
      test_nop();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
